wt_store_wbuffer: RTL and testbench



---
 rtl/wt_store_wbuffer_pkg.sv | 44 ++++
 rtl/wbuf_fwd_mux.sv | 55 +++++
 rtl/wt_store_wbuffer.sv | 187 ++++++++++++++++++
 tb/tb_wt_store_wbuffer.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wt_store_wbuffer_pkg.sv
// -----------------------------------------------------------------------------
// wt_store_wbuffer_pkg
// Shared types for the write-through store buffer and its forwarding mux.
//   wbuf_state_e : life cycle of one buffer entry (FREE -> VALID -> SENT -> FREE)
//   wbuf_entry_t : one buffer entry (word address, data, byte enables, state)
//   wbuf_merge   : byte-lane merge of new store data over existing data
// Widths follow the core configuration (Sv32 physical address, 64-bit words).
// -----------------------------------------------------------------------------
package wt_store_wbuffer_pkg;

    localparam int WBUF_PLEN    = 34;
    localparam int WBUF_DATA_W  = 64;
    localparam int WBUF_BE_W    = WBUF_DATA_W / 8;
    localparam int WBUF_OFF_W   = $clog2(WBUF_BE_W);
    localparam int WBUF_WADDR_W = WBUF_PLEN - WBUF_OFF_W;

    typedef enum logic [1:0] {
        FREE  = 2'd0,
        VALID = 2'd1,
        SENT  = 2'd2
    } wbuf_state_e;

    typedef struct packed {
        logic [WBUF_WADDR_W-1:0] addr;   // word address (byte offset dropped)
        logic [WBUF_DATA_W-1:0]  data;
        logic [WBUF_BE_W-1:0]    be;
        wbuf_state_e             state;
    } wbuf_entry_t;

    // Replace the byte lanes selected by be with new_data, keep the rest.
    function automatic logic [WBUF_DATA_W-1:0] wbuf_merge(
        input logic [WBUF_DATA_W-1:0] old_data,
        input logic [WBUF_DATA_W-1:0] new_data,
        input logic [WBUF_BE_W-1:0]   be
    );
        logic [WBUF_DATA_W-1:0] res;
        res = old_data;
        for (int b = 0; b < WBUF_BE_W; b++) begin
            if (be[b]) res[b*8 +: 8] = new_data[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/wbuf_fwd_mux.sv
// -----------------------------------------------------------------------------
// wbuf_fwd_mux
// Combinational newest-match byte selection for store-to-load forwarding.
// Entries are visited from oldest to newest so a later hit overwrites an
// earlier one: all SENT entries first, then all VALID entries, each class in
// ring order starting at the issue pointer.
// Ports:
//   iss_ptr_i     : current issue pointer (age reference)
//   match_valid_i : per entry, VALID and word address matches
//   match_sent_i  : per entry, SENT and word address matches
//   be_i / data_i : per-entry byte enables and data
//   hit_be_o      : OR of matching byte enables
//   hit_data_o    : newest matching byte per lane, 0 where no hit
// -----------------------------------------------------------------------------
module wbuf_fwd_mux #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 64
) (
    input  logic [$clog2(DEPTH)-1:0]       iss_ptr_i,
    input  logic [DEPTH-1:0]               match_valid_i,
    input  logic [DEPTH-1:0]               match_sent_i,
    input  logic [DEPTH-1:0][DATA_W/8-1:0] be_i,
    input  logic [DEPTH-1:0][DATA_W-1:0]   data_i,
    output logic [DATA_W/8-1:0]            hit_be_o,
    output logic [DATA_W-1:0]              hit_data_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int BE_W  = DATA_W / 8;

    logic [PTR_W-1:0] idx;
    logic             sel;

    // NOTE: every variable written here gets a value before any conditional
    // assignment; otherwise the missing paths would infer latches.
    always_comb begin
        hit_be_o   = '0;
        hit_data_o = '0;
        idx        = iss_ptr_i;
        sel        = 1'b0;
        for (int cls = 0; cls < 2; cls++) begin
            for (int d = 0; d < DEPTH; d++) begin
                idx = iss_ptr_i + PTR_W'(d);
                sel = (cls == 0) ? match_sent_i[idx] : match_valid_i[idx];
                for (int b = 0; b < BE_W; b++) begin
                    if (sel && be_i[idx][b]) begin
                        hit_be_o[b]          = 1'b1;
                        hit_data_o[b*8 +: 8] = data_i[idx][b*8 +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/wt_store_wbuffer.sv
// -----------------------------------------------------------------------------
// wt_store_wbuffer
// Write-through store buffer between the store unit and the dcache memory
// interface. Consecutive stores to the same 64-bit word merge into the newest
// entry; entries drain in allocation order via req/gnt, and are released by
// (possibly out-of-order) acks tagged with the entry index.
// Ports:
//   clk_i, rst_ni                : clock, async active-low reset
//   st_req_i / st_ready_o        : store valid / accepted this cycle
//   st_addr_i, st_data_i, st_be_i: store address (bits [2:0] ignored), data, be
//   mem_req_o / mem_gnt_i        : drain request / grant
//   mem_addr_o, mem_data_o,
//   mem_be_o, mem_tid_o          : issuing entry fields, tid = entry index
//   mem_ack_i, mem_ack_tid_i     : write completion and completing entry
//   ld_addr_i                    : load lookup address
//   ld_hit_be_o, ld_hit_data_o   : forwarded byte enables and data
//   empty_o                      : all entries FREE
// -----------------------------------------------------------------------------
module wt_store_wbuffer
    import wt_store_wbuffer_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int PLEN   = WBUF_PLEN,
    parameter int DATA_W = WBUF_DATA_W,
    parameter int TID_W  = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                st_req_i,
    output logic                st_ready_o,
    input  logic [PLEN-1:0]     st_addr_i,
    input  logic [DATA_W-1:0]   st_data_i,
    input  logic [DATA_W/8-1:0] st_be_i,
    output logic                mem_req_o,
    input  logic                mem_gnt_i,
    output logic [PLEN-1:0]     mem_addr_o,
    output logic [DATA_W-1:0]   mem_data_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    output logic [TID_W-1:0]    mem_tid_o,
    input  logic                mem_ack_i,
    input  logic [TID_W-1:0]    mem_ack_tid_i,
    input  logic [PLEN-1:0]     ld_addr_i,
    output logic [DATA_W/8-1:0] ld_hit_be_o,
    output logic [DATA_W-1:0]   ld_hit_data_o,
    output logic                empty_o
);

    localparam int BE_W  = DATA_W / 8;
    localparam int OFF_W = $clog2(BE_W);
    localparam int PTR_W = $clog2(DEPTH);

    wbuf_entry_t [DEPTH-1:0] entry_q, entry_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        iss_ptr_q, iss_ptr_d;

    logic [PTR_W-1:0]        newest_idx;
    logic [PTR_W-1:0]        ack_idx;
    logic [PLEN-OFF_W-1:0]   st_waddr;
    logic [PLEN-OFF_W-1:0]   ld_waddr;
    logic                    issue;
    logic                    grant;
    logic                    merge_ok;
    logic                    alloc_ok;
    logic                    st_fire;

    logic [DEPTH-1:0]             match_valid;
    logic [DEPTH-1:0]             match_sent;
    logic [DEPTH-1:0][BE_W-1:0]   ent_be;
    logic [DEPTH-1:0][DATA_W-1:0] ent_data;

    // Byte offsets and tid bits above the entry index carry no information here.
    logic unused_bits;
    assign unused_bits = ^{st_addr_i[OFF_W-1:0], ld_addr_i[OFF_W-1:0], mem_ack_tid_i};

    assign newest_idx = wr_ptr_q - PTR_W'(1);
    assign ack_idx    = mem_ack_tid_i[PTR_W-1:0];
    assign st_waddr   = st_addr_i[PLEN-1:OFF_W];
    assign ld_waddr   = ld_addr_i[PLEN-1:OFF_W];

    // ---------------------------------------------------------------- drain
    assign issue     = (entry_q[iss_ptr_q].state == VALID);
    assign grant     = issue & mem_gnt_i;
    assign mem_req_o = issue;

    // Fields read 0 when idle. A pending (ungranted) request may still pick up
    // merged bytes; memory samples the fields at the grant.
    assign mem_addr_o = issue ? {entry_q[iss_ptr_q].addr, {OFF_W{1'b0}}} : '0;
    assign mem_data_o = issue ? entry_q[iss_ptr_q].data : '0;
    assign mem_be_o   = issue ? entry_q[iss_ptr_q].be : '0;
    assign mem_tid_o  = issue ? TID_W'(iss_ptr_q) : '0;

    // ----------------------------------------------------- store acceptance
    // Merging into the entry that is leaving this cycle would lose bytes, so
    // that case falls through to allocation.
    assign merge_ok = (entry_q[newest_idx].state == VALID)
                    && (entry_q[newest_idx].addr == st_waddr)
                    && !(grant && (newest_idx == iss_ptr_q));
    assign alloc_ok = (entry_q[wr_ptr_q].state == FREE);

    // Reset forces ready low at once, even though the entries look FREE.
    assign st_ready_o = rst_ni & (merge_ok | alloc_ok);
    assign st_fire    = st_req_i & st_ready_o;

    always_comb begin
        entry_d   = entry_q;
        wr_ptr_d  = wr_ptr_q;
        iss_ptr_d = iss_ptr_q;

        if (st_fire) begin
            if (merge_ok) begin
                entry_d[newest_idx].data = wbuf_merge(entry_q[newest_idx].data,
                                                      st_data_i, st_be_i);
                entry_d[newest_idx].be   = entry_q[newest_idx].be | st_be_i;
            end else begin
                entry_d[wr_ptr_q].addr  = st_waddr;
                entry_d[wr_ptr_q].data  = wbuf_merge('0, st_data_i, st_be_i);
                entry_d[wr_ptr_q].be    = st_be_i;
                entry_d[wr_ptr_q].state = VALID;
                wr_ptr_d                = wr_ptr_q + PTR_W'(1);
            end
        end

        if (grant) begin
            entry_d[iss_ptr_q].state = SENT;
            iss_ptr_d                = iss_ptr_q + PTR_W'(1);
        end

        // Acks for entries not in flight are dropped.
        if (mem_ack_i && (entry_q[ack_idx].state == SENT)) begin
            entry_d[ack_idx].state = FREE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    // NOTE: the entry array is reset in full; the state field must be FREE and
    // zeroed payload keeps outputs deterministic after a mid-drain reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            entry_q   <= '0;
            wr_ptr_q  <= '0;
            iss_ptr_q <= '0;
        end else begin
            entry_q   <= entry_d;
            wr_ptr_q  <= wr_ptr_d;
            iss_ptr_q <= iss_ptr_d;
        end
    end

    // ---------------------------------------------------------------- empty
    always_comb begin
        empty_o = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_q[i].state != FREE) empty_o = 1'b0;
        end
    end

    // ------------------------------------------------------- load forwarding
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            match_valid[i] = (entry_q[i].state == VALID) && (entry_q[i].addr == ld_waddr);
            match_sent[i]  = (entry_q[i].state == SENT)  && (entry_q[i].addr == ld_waddr);
            ent_be[i]      = entry_q[i].be;
            ent_data[i]    = entry_q[i].data;
        end
    end

    wbuf_fwd_mux #(
        .DEPTH (DEPTH),
        .DATA_W(DATA_W)
    ) u_fwd_mux (
        .iss_ptr_i    (iss_ptr_q),
        .match_valid_i(match_valid),
        .match_sent_i (match_sent),
        .be_i         (ent_be),
        .data_i       (ent_data),
        .hit_be_o     (ld_hit_be_o),
        .hit_data_o   (ld_hit_data_o)
    );

    // An ack must name an entry that is in flight.
    ack_targets_sent: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        mem_ack_i |-> (entry_q[ack_idx].state == SENT)
    );

endmodule

// File: tb/tb_wt_store_wbuffer.sv
// -----------------------------------------------------------------------------
// tb_wt_store_wbuffer
// Directed scenarios (merge/drain, full stall, issue/merge collision,
// out-of-order ack, forwarding, async reset) followed by a randomized phase
// checked against a queue-based model of the buffer.
// -----------------------------------------------------------------------------
module tb_wt_store_wbuffer;

    localparam int DEPTH  = 2;
    localparam int PLEN   = 34;
    localparam int DATA_W = 64;
    localparam int BE_W   = 8;
    localparam int TID_W  = 2;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic              st_req_i;
    logic              st_ready_o;
    logic [PLEN-1:0]   st_addr_i;
    logic [DATA_W-1:0] st_data_i;
    logic [BE_W-1:0]   st_be_i;
    logic              mem_req_o;
    logic              mem_gnt_i;
    logic [PLEN-1:0]   mem_addr_o;
    logic [DATA_W-1:0] mem_data_o;
    logic [BE_W-1:0]   mem_be_o;
    logic [TID_W-1:0]  mem_tid_o;
    logic              mem_ack_i;
    logic [TID_W-1:0]  mem_ack_tid_i;
    logic [PLEN-1:0]   ld_addr_i;
    logic [BE_W-1:0]   ld_hit_be_o;
    logic [DATA_W-1:0] ld_hit_data_o;
    logic              empty_o;

    wt_store_wbuffer #(
        .DEPTH (DEPTH),
        .PLEN  (PLEN),
        .DATA_W(DATA_W),
        .TID_W (TID_W)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .st_req_i     (st_req_i),
        .st_ready_o   (st_ready_o),
        .st_addr_i    (st_addr_i),
        .st_data_i    (st_data_i),
        .st_be_i      (st_be_i),
        .mem_req_o    (mem_req_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_be_o     (mem_be_o),
        .mem_tid_o    (mem_tid_o),
        .mem_ack_i    (mem_ack_i),
        .mem_ack_tid_i(mem_ack_tid_i),
        .ld_addr_i    (ld_addr_i),
        .ld_hit_be_o  (ld_hit_be_o),
        .ld_hit_data_o(ld_hit_data_o),
        .empty_o      (empty_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        st_req_i      = 1'b0;
        st_addr_i     = '0;
        st_data_i     = '0;
        st_be_i       = '0;
        mem_gnt_i     = 1'b0;
        mem_ack_i     = 1'b0;
        mem_ack_tid_i = '0;
        ld_addr_i     = '0;
    endtask

    // Advance past the next rising edge; inputs are then driven mid-cycle.
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        idle_inputs();
        cyc();
        cyc();
        rst_ni = 1'b1;
        cyc();
    endtask

    task automatic store(input logic [PLEN-1:0] a, input logic [BE_W-1:0] be,
                         input logic [DATA_W-1:0] d);
        st_req_i  = 1'b1;
        st_addr_i = a;
        st_be_i   = be;
        st_data_i = d;
    endtask

    function automatic logic [DATA_W-1:0] be_mask(input logic [BE_W-1:0] be);
        logic [DATA_W-1:0] m;
        for (int b = 0; b < BE_W; b++) m[b*8 +: 8] = {8{be[b]}};
        return m;
    endfunction

    // ---------------------------------------------------------- reference model
    // Live entries kept in allocation order (oldest first). Slot numbers are the
    // transaction ids; a new entry takes slot (allocations so far) mod DEPTH.
    logic [PLEN-1:0]   m_addr[DEPTH];
    logic [DATA_W-1:0] m_data[DEPTH];
    logic [BE_W-1:0]   m_be[DEPTH];
    bit                m_sent[DEPTH];
    int                order[$];
    int                alloc_cnt;

    initial begin
        logic [DATA_W-1:0] ra, rb;
        bit                stalled;
        bit                exp_req, granting, exp_merge, slot_free, exp_ready;
        int                iss_slot, next_slot, newest;
        int                sent_list[$];
        logic [BE_W-1:0]   exp_hb;
        logic [DATA_W-1:0] exp_hd;

        // ---------------- reset state (store pending to see ready held low)
        idle_inputs();
        store(34'h0_8000_0000, 8'hFF, 64'h1);
        #2;
        check("rst_ready", st_ready_o, 1'b0);
        check("rst_req", mem_req_o, 1'b0);
        check("rst_empty", empty_o, 1'b1);
        check("rst_hit_be", ld_hit_be_o, '0);
        check("rst_mem_addr", mem_addr_o, '0);
        check("rst_mem_data", mem_data_o, '0);
        check("rst_mem_be", mem_be_o, '0);
        check("rst_mem_tid", mem_tid_o, '0);

        // ---------------- merge then drain
        do_reset();
        store(34'h0_8000_0010, 8'h0F, 64'h0000_0000_1122_3344);
        settle();
        check("t1_ready_a", st_ready_o, 1'b1);
        check("t1_no_req_yet", mem_req_o, 1'b0);
        cyc();
        store(34'h0_8000_0010, 8'hF0, 64'h5566_7788_0000_0000);
        settle();
        check("t1_ready_merge", st_ready_o, 1'b1);
        check("t1_req_first", mem_req_o, 1'b1);
        cyc();
        st_req_i = 1'b0;
        settle();
        check("t1_req", mem_req_o, 1'b1);
        check("t1_be", mem_be_o, 8'hFF);
        check("t1_data", mem_data_o, 64'h5566_7788_1122_3344);
        check("t1_tid", mem_tid_o, 2'd0);
        check("t1_addr", mem_addr_o, 34'h0_8000_0010);
        mem_gnt_i = 1'b1;
        cyc();
        mem_gnt_i = 1'b0;
        settle();
        check("t1_req_after_gnt", mem_req_o, 1'b0);
        check("t1_not_empty_sent", empty_o, 1'b0);
        mem_ack_i     = 1'b1;
        mem_ack_tid_i = 2'd0;
        cyc();
        mem_ack_i = 1'b0;
        settle();
        check("t1_empty_after_ack", empty_o, 1'b1);

        // ---------------- full stall
        do_reset();
        ra = {$urandom, $urandom};
        rb = {$urandom, $urandom};
        store(34'h0_8000_0000, 8'hFF, ra);
        cyc();
        store(34'h0_8000_0100, 8'hFF, rb);
        settle();
        check("t2_ready_second", st_ready_o, 1'b1);
        cyc();
        store(34'h0_8000_0200, 8'hFF, 64'h0123_4567_89AB_CDEF);
        settle();
        check("t2_stall_full", st_ready_o, 1'b0);
        mem_gnt_i = 1'b1;
        cyc();
        mem_gnt_i = 1'b0;
        settle();
        check("t2_stall_sent", st_ready_o, 1'b0);
        mem_ack_i     = 1'b1;
        mem_ack_tid_i = 2'd0;
        settle();
        check("t2_stall_ack_cycle", st_ready_o, 1'b0);
        cyc();
        mem_ack_i = 1'b0;
        settle();
        check("t2_ready_after_ack", st_ready_o, 1'b1);
        cyc();
        st_req_i = 1'b0;
        settle();
        check("t2_req_second", mem_req_o, 1'b1);
        check("t2_tid_second", mem_tid_o, 2'd1);
        check("t2_addr_second", mem_addr_o, 34'h0_8000_0100);
        check("t2_data_second", mem_data_o, rb);

        // ---------------- issue/merge collision
        do_reset();
        store(34'h0_8000_0040, 8'h0F, 64'h0000_0000_A1A2_A3A4);
        cyc();
        store(34'h0_8000_0040, 8'hF0, 64'hB1B2_B3B4_0000_0000);
        mem_gnt_i = 1'b1;
        settle();
        check("t3_ready", st_ready_o, 1'b1);
        check("t3_sent_be", mem_be_o, 8'h0F);
        check("t3_sent_data", mem_data_o, 64'h0000_0000_A1A2_A3A4);
        check("t3_sent_tid", mem_tid_o, 2'd0);
        cyc();
        st_req_i  = 1'b0;
        mem_gnt_i = 1'b0;
        ld_addr_i = 34'h0_8000_0040;
        settle();
        check("t3_new_req", mem_req_o, 1'b1);
        check("t3_new_tid", mem_tid_o, 2'd1);
        check("t3_new_be", mem_be_o, 8'hF0);
        check("t3_new_data", mem_data_o, 64'hB1B2_B3B4_0000_0000);
        check("t3_fwd_be", ld_hit_be_o, 8'hFF);
        check("t3_fwd_data", ld_hit_data_o, 64'hB1B2_B3B4_A1A2_A3A4);

        // ---------------- out-of-order ack
        do_reset();
        store(34'h0_8000_0000, 8'hFF, {$urandom, $urandom});
        cyc();
        store(34'h0_8000_0008, 8'hFF, {$urandom, $urandom});
        mem_gnt_i = 1'b1;
        settle();
        check("t4_ready_b", st_ready_o, 1'b1);
        check("t4_tid0", mem_tid_o, 2'd0);
        cyc();
        st_req_i = 1'b0;
        settle();
        check("t4_tid1", mem_tid_o, 2'd1);
        cyc();
        mem_gnt_i     = 1'b0;
        mem_ack_i     = 1'b1;
        mem_ack_tid_i = 2'd1;
        cyc();
        mem_ack_i = 1'b0;
        store(34'h0_8000_0010, 8'h3C, 64'h0000_DEAD_BEEF_0000);
        settle();
        check("t4_stall_after_ack1", st_ready_o, 1'b0);
        check("t4_not_empty", empty_o, 1'b0);
        cyc();
        mem_ack_i     = 1'b1;
        mem_ack_tid_i = 2'd0;
        settle();
        check("t4_stall_ack0_cycle", st_ready_o, 1'b0);
        cyc();
        mem_ack_i = 1'b0;
        settle();
        check("t4_empty_both", empty_o, 1'b1);
        check("t4_ready_after_ack0", st_ready_o, 1'b1);
        cyc();
        st_req_i = 1'b0;
        settle();
        check("t4_req_c", mem_req_o, 1'b1);
        check("t4_tid_c", mem_tid_o, 2'd0);
        check("t4_be_c", mem_be_o, 8'h3C);
        check("t4_empty_c", empty_o, 1'b0);

        // ---------------- forwarding: SENT older than VALID
        do_reset();
        store(34'h0_8000_0020, 8'hFF, 64'hAAAA_AAAA_AAAA_AAAA);
        cyc();
        st_req_i  = 1'b0;
        mem_gnt_i = 1'b1;
        cyc();
        mem_gnt_i = 1'b0;
        store(34'h0_8000_0020, 8'h01, 64'h0000_0000_0000_00BB);
        settle();
        check("t5_ready_alloc", st_ready_o, 1'b1);
        cyc();
        st_req_i  = 1'b0;
        ld_addr_i = 34'h0_8000_0025;
        settle();
        check("t5_fwd_be", ld_hit_be_o, 8'hFF);
        check("t5_fwd_data", ld_hit_data_o, 64'hAAAA_AAAA_AAAA_AABB);
        ld_addr_i = 34'h0_8000_0028;
        settle();
        check("t5_miss_be", ld_hit_be_o, 8'h00);
        check("t5_miss_data", ld_hit_data_o, 64'h0);

        // ---------------- async reset mid-drain
        check("t6_req_before", mem_req_o, 1'b1);
        rst_ni = 1'b0;
        #2;
        check("t6_req_async", mem_req_o, 1'b0);
        check("t6_empty_async", empty_o, 1'b1);
        check("t6_tid_async", mem_tid_o, '0);
        check("t6_be_async", mem_be_o, '0);

        // ---------------- randomized phase
        do_reset();
        order.delete();
        alloc_cnt = 0;
        stalled   = 1'b0;
        for (int cycle = 0; cycle < 1500; cycle++) begin
            if (!stalled) begin
                if ($urandom_range(0, 9) < 6) begin
                    store(34'h0_8000_0000 + 34'($urandom_range(0, 3) * 8 + $urandom_range(0, 7)),
                          8'($urandom_range(1, 255)), {$urandom, $urandom});
                end else begin
                    st_req_i = 1'b0;
                end
            end
            mem_gnt_i = 1'($urandom_range(0, 1));
            sent_list.delete();
            foreach (order[k]) if (m_sent[order[k]]) sent_list.push_back(order[k]);
            mem_ack_i = 1'b0;
            if (sent_list.size() > 0 && $urandom_range(0, 9) < 4) begin
                mem_ack_i     = 1'b1;
                mem_ack_tid_i = 2'(sent_list[$urandom_range(0, sent_list.size() - 1)]);
            end
            ld_addr_i = 34'h0_8000_0000 + 34'($urandom_range(0, 4) * 8 + $urandom_range(0, 7));
            settle();

            exp_req  = 1'b0;
            iss_slot = 0;
            foreach (order[k]) begin
                if (!exp_req && !m_sent[order[k]]) begin
                    exp_req  = 1'b1;
                    iss_slot = order[k];
                end
            end
            granting  = exp_req && mem_gnt_i;
            newest    = (order.size() > 0) ? order[order.size() - 1] : 0;
            exp_merge = (order.size() > 0) && !m_sent[newest]
                        && (m_addr[newest][PLEN-1:3] == st_addr_i[PLEN-1:3])
                        && !(granting && newest == iss_slot);
            next_slot = alloc_cnt % DEPTH;
            slot_free = 1'b1;
            foreach (order[k]) if (order[k] == next_slot) slot_free = 1'b0;
            exp_ready = exp_merge || slot_free;

            exp_hb = '0;
            exp_hd = '0;
            foreach (order[k]) begin
                if (m_addr[order[k]][PLEN-1:3] == ld_addr_i[PLEN-1:3]) begin
                    for (int b = 0; b < BE_W; b++) begin
                        if (m_be[order[k]][b]) begin
                            exp_hb[b]        = 1'b1;
                            exp_hd[b*8 +: 8] = m_data[order[k]][b*8 +: 8];
                        end
                    end
                end
            end

            if (st_req_i) check("rnd_ready", st_ready_o, exp_ready);
            check("rnd_req", mem_req_o, exp_req);
            if (exp_req) begin
                check("rnd_addr", mem_addr_o, m_addr[iss_slot]);
                check("rnd_tid", mem_tid_o, 2'(iss_slot));
                check("rnd_be", mem_be_o, m_be[iss_slot]);
                check("rnd_data", mem_data_o & be_mask(m_be[iss_slot]), m_data[iss_slot]);
            end
            check("rnd_empty", empty_o, order.size() == 0);
            check("rnd_hit_be", ld_hit_be_o, exp_hb);
            check("rnd_hit_data", ld_hit_data_o, exp_hd);

            if (st_req_i && exp_ready) begin
                if (exp_merge) begin
                    m_data[newest] = (m_data[newest] & ~be_mask(st_be_i))
                                   | (st_data_i & be_mask(st_be_i));
                    m_be[newest]   = m_be[newest] | st_be_i;
                end else begin
                    m_addr[next_slot] = {st_addr_i[PLEN-1:3], 3'b000};
                    m_data[next_slot] = st_data_i & be_mask(st_be_i);
                    m_be[next_slot]   = st_be_i;
                    m_sent[next_slot] = 1'b0;
                    order.push_back(next_slot);
                    alloc_cnt++;
                end
            end
            if (granting) m_sent[iss_slot] = 1'b1;
            if (mem_ack_i) begin
                for (int k = order.size() - 1; k >= 0; k--) begin
                    if (order[k] == int'(mem_ack_tid_i)) order.delete(k);
                end
            end
            stalled = st_req_i && !exp_ready;
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
